// File: rtl/req_arbiter_if.sv
// Request/grant bundle between 8 requesters and the shared-resource arbiter.
// Handshake: req[i] is a level request; gnt/gnt_id/gnt_valid are registered and hold while the owner keeps req[i] high.
interface req_arbiter_if #(
    parameter int MAX_HOLD = 16
);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    logic [7:0]    req;
    logic          mode;
    logic [7:0]    gnt;
    logic [2:0]    gnt_id;
    logic          gnt_valid;
    logic          expire;
    logic          dbg_state;      // 1 = BUSY
    logic [HW-1:0] dbg_hold_cnt;

    modport master (
        output req, mode,
        input  gnt, gnt_id, gnt_valid, expire, dbg_state, dbg_hold_cnt
    );

    modport slave (
        input  req, mode,
        output gnt, gnt_id, gnt_valid, expire, dbg_state, dbg_hold_cnt
    );
endinterface

// File: rtl/req_arbiter.sv
// 8-way arbiter with fixed-priority or round-robin selection, grant holding
// and an optional hold limit that forces re-arbitration.
module req_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    req_arbiter_if.slave  bus
);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [2:0]    last_id;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    gnt_r;
    logic [2:0]    gnt_id_r;
    logic          gnt_valid_r;
    logic          expire_r;

    logic [7:0]    cand;
    logic [2:0]    start;
    logic [2:0]    win;
    logic          owner_req;
    logic          hold_ok;

    // Descending search from start with wrap; the later loop iterations
    // override earlier ones, so the bit at start has the highest priority.
    function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] s);
        logic [2:0] w;
        logic [2:0] idx;
        w = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = s - 3'(i);
            if (c[idx]) w = idx;
        end
        return w;
    endfunction

    always_comb begin
        owner_req = bus.req[gnt_id_r];
        hold_ok   = (MAX_HOLD == 0) || (hold_cnt < HOLD_LIM);
        cand      = bus.req;
        if (state == BUSY) cand = bus.req & ~(8'b1 << gnt_id_r);
        start     = bus.mode ? (last_id - 3'd1) : 3'd7;
        win       = pick(cand, start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_id     <= 3'd0;
            hold_cnt    <= '0;
            gnt_r       <= 8'd0;
            gnt_id_r    <= 3'd0;
            gnt_valid_r <= 1'b0;
            expire_r    <= 1'b0;
        end else begin
            expire_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand != 8'd0) begin
                        state       <= BUSY;
                        gnt_r       <= 8'b1 << win;
                        gnt_id_r    <= win;
                        gnt_valid_r <= 1'b1;
                        last_id     <= win;
                        hold_cnt    <= HW'(1);
                    end
                end
                BUSY: begin
                    if (owner_req && hold_ok) begin
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                    end else if (cand != 8'd0) begin
                        // Release or expiry with another requester: direct hand-off.
                        gnt_r    <= 8'b1 << win;
                        gnt_id_r <= win;
                        last_id  <= win;
                        hold_cnt <= HW'(1);
                        expire_r <= owner_req;
                    end else if (owner_req) begin
                        // Expired but nobody else wants it: re-grant the owner.
                        last_id  <= gnt_id_r;
                        hold_cnt <= HW'(1);
                    end else begin
                        state       <= IDLE;
                        gnt_r       <= 8'd0;
                        gnt_id_r    <= 3'd0;
                        gnt_valid_r <= 1'b0;
                        hold_cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.gnt_id       = gnt_id_r;
    assign bus.gnt_valid    = gnt_valid_r;
    assign bus.expire       = expire_r;
    assign bus.dbg_state    = (state == BUSY);
    assign bus.dbg_hold_cnt = hold_cnt;
endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Shares one downstream resource between 8 requesters.
- Registered grant FSM built around an 8-bit priority search. Two modes: fixed priority, where the MSB wins, and round-robin.
- Holds a grant while the owner keeps requesting, with an optional hold-limit that forces re-arbitration.
- Sits between request sources and a shared bus or port; gnt_id drives the resource mux select.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced re-arbitration; 0 = unlimited

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  8  request vector; req[i] high = requester i wants the resource
mode  input  1  0 = fixed priority (bit 7 highest), 1 = round-robin
gnt  output  8  one-hot grant, all-zero when idle
gnt_id  output  3  binary index of current owner; valid only when gnt_valid=1
gnt_valid  output  1  high while any grant is held
expire  output  1  one-cycle pulse in the first cycle of a grant that replaced an expired owner

Behaviour:
- Reset (rst=1 at edge) clears state and outputs:
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, expire=0.
  - last_id=0, hold_cnt=0.
  - rst has priority over all other events, including mid-grant; the grant drops on the following cycle.
- All outputs are registered. Latency is 1 cycle: req sampled at edge N, gnt visible after edge N.
- States are IDLE and BUSY.
- Arbitration function, evaluated on the candidate vector C:
  - mode=0: the highest set index in C wins.
  - mode=1: search starts at index (last_id-1) mod 8, descends, and wraps 0->7. The first set bit wins.
  - After reset, last_id=0, so round-robin matches fixed priority (search starts at 7).
- IDLE:
  - If req!=0: C=req, grant the winner, go to BUSY, hold_cnt=1, last_id=winner.
  - Else stay in IDLE with outputs zero.
- BUSY, owner o:
  - Hold: req[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD). Keep the grant and increment hold_cnt; it saturates, with no wrap.
  - Release: req[o]=0. Set C=req, with bit o already 0.
    - If C!=0, the new winner is granted at the same edge. There is no idle bubble and gnt changes directly between one-hot values.
    - If C=0, go to IDLE and set gnt=0 next cycle.
  - Expire: req[o]=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD. Set C=req with bit o cleared.
    - If C!=0: grant the winner, hold_cnt=1, expire=1 for that one cycle.
    - If C=0: re-grant o, hold_cnt=1, expire=0.
- On every new grant, including a re-grant after expiry: last_id=winner, hold_cnt=1.
- A mode change is sampled only at an arbitration edge and never preempts a held grant.
- Requests from non-owners never preempt, regardless of their priority.
- gnt is always one-hot or zero. gnt==(1<<gnt_id) whenever gnt_valid=1.
- hold_cnt width is ceil(log2(MAX_HOLD+1)), minimum 1 bit.

Test Plan:
1. Reset mid-grant: req=8'h80 held 3 cycles, then rst=1 for 1 cycle -> the cycle after reset shows gnt=0, gnt_valid=0, gnt_id=0, expire=0.
2. Fixed priority with hand-off, mode=0:
   - req=8'b0010_0110 -> gnt=8'h20, gnt_id=5 one cycle later.
   - Drop req[5] -> next cycle gnt=8'h04, gnt_id=2, with no zero cycle in between.
3. Round-robin rotation, mode=1, req=8'hFF held:
   - With MAX_HOLD=16, each owner is granted for 16 cycles with expire=1 on each new grant.
   - gnt_id sequence is 7,6,5,...,0,7.
4. Lone requester expiry, MAX_HOLD=4, req=8'h08 constant -> gnt=8'h08 continuous, hold_cnt cycles 1..4 and restarts, expire stays 0.
5. Non-preemption, mode=0: owner 1 granted, then req[7] rises while req[1]=1 -> gnt stays 8'h02 until req[1]=0, then gnt=8'h80.
6. Idle return: single owner 3 drops its request with all other req=0 -> next cycle gnt=0 and gnt_valid=0. A new req=8'h01 gives gnt_id=0 one cycle later.
